// File: rtl/nw_pkg.sv
// nw_pkg: shared definitions for the Needleman-Wunsch fill sequencer.
//   - default score width, gap penalty, match/mismatch scores
//   - traceback arrow encodings (one-hot: lx / up / diag)
//   - fill sequencer state enum
//   - 2-bit nucleotide codes
package nw_pkg;

    localparam int SW_DEF   = 9;
    localparam int GAP_DEF  = -2;
    localparam int MATCH    = 1;
    localparam int MISMATCH = -1;

    localparam logic [2:0] ARROW_LX   = 3'b100;
    localparam logic [2:0] ARROW_UP   = 3'b010;
    localparam logic [2:0] ARROW_DIAG = 3'b001;

    localparam logic [1:0] NT_A = 2'd0;
    localparam logic [1:0] NT_C = 2'd1;
    localparam logic [1:0] NT_G = 2'd2;
    localparam logic [1:0] NT_T = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } nw_state_e;

endpackage

// File: rtl/nw_row_buf.sv
// nw_row_buf: one row of the score matrix, N+1 entries of SW bits.
// Ports:
//   clk              clock
//   we/waddr/wdata   single synchronous write port
//   raddr_a/rdata_a  combinational read port (entry j, the "up" score)
//   raddr_b/rdata_b  combinational read port (entry j-1, the "left" score)
// Contents are not reset; the fill sequencer initialises every entry
// before any of them is read.
module nw_row_buf #(
    parameter  int N  = 8,
    parameter  int SW = 9,
    localparam int AW = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [SW-1:0] wdata,
    input  logic [AW-1:0]        raddr_a,
    output logic signed [SW-1:0] rdata_a,
    input  logic [AW-1:0]        raddr_b,
    output logic signed [SW-1:0] rdata_b
);

    logic signed [SW-1:0] mem [0:N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/nw_fill_ctrl.sv
// nw_fill_ctrl: sequencer for the Needleman-Wunsch score-matrix fill.
// Walks cells (i,j), i,j = 1..N, row-major. For each cell it presents
// diag/up/lx and the match flag to an external max-cell unit (ISSUE),
// then captures the cell score and arrow (CAPTURE), writing the arrow to
// the traceback memory. One row of scores lives in nw_row_buf.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, accepted only in IDLE
//   a_idx, b_idx        character indices (i-1, j-1)
//   a_char, b_char      characters returned combinationally
//   value               1 when a_char == b_char (to max cell)
//   diag, up, lx        signed operands to the max cell
//   max_in, symbol_in   score and arrow from the max cell
//   tb_we/addr/data     traceback write port, addr = (i-1)*N + (j-1)
//   busy                first INIT cycle through last CAPTURE
//   done                one-cycle pulse after the last cell
//   final_score         score(N,N), held until the next accepted start
//   state               current sequencer state (debug)
//
// Optional build macro NW_SCORE_OUT_EN adds score_we / score_data, which
// mirror each traceback write with the cell score itself.
module nw_fill_ctrl
    import nw_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int GAP = GAP_DEF,
    parameter  int SW  = SW_DEF,
    localparam int IW  = $clog2(N),
    localparam int JW  = $clog2(N + 1),
    localparam int AW  = $clog2(N * N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [IW-1:0]        a_idx,
    output logic [IW-1:0]        b_idx,
    input  logic [1:0]           a_char,
    input  logic [1:0]           b_char,
    output logic                 value,
    output logic signed [SW-1:0] diag,
    output logic signed [SW-1:0] up,
    output logic signed [SW-1:0] lx,
    input  logic signed [SW-1:0] max_in,
    input  logic [2:0]           symbol_in,
    output logic                 tb_we,
    output logic [AW-1:0]        tb_addr,
    output logic [2:0]           tb_data,
    output logic                 busy,
    output logic                 done,
    output logic signed [SW-1:0] final_score,
    output nw_state_e            state
`ifdef NW_SCORE_OUT_EN
    ,
    output logic                 score_we,
    output logic signed [SW-1:0] score_data
`endif
);

    localparam logic signed [SW-1:0] GAP_S = SW'(GAP);

    logic [IW-1:0]        i_m1;     // row index i-1
    logic [IW-1:0]        j_m1;     // column index j-1
    logic [JW-1:0]        k;        // INIT entry counter, 0..N
    logic signed [SW-1:0] border;   // INIT: k*GAP; fill: score(i,0) = i*GAP
    logic signed [SW-1:0] diag_r;
    logic signed [SW-1:0] lx_r;

    logic [JW-1:0]        j_idx;
    logic                 last_col;
    logic                 last_row;
    logic                 active;

    logic                 wr_en;
    logic [JW-1:0]        wr_addr;
    logic signed [SW-1:0] wr_data;
    logic signed [SW-1:0] rd_up;
    logic signed [SW-1:0] rd_left;

    assign j_idx    = JW'(j_m1) + JW'(1);
    assign last_col = (j_m1 == IW'(N - 1));
    assign last_row = (i_m1 == IW'(N - 1));
    assign active   = (state == ISSUE) || (state == CAPTURE);

    // Row buffer write port. Besides INIT and the per-cell score write,
    // entry 0 takes score(i-1,0) during the first ISSUE of each row; that
    // keeps the border write off the CAPTURE cycle, which already owns the
    // port for entry N. Entry 0 is never needed as an operand because the
    // j=1 diag and lx come from diag_r / lx_r.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = k;
                wr_data = border;
            end
            ISSUE: begin
                if (j_m1 == '0) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_data = diag_r;
                end
            end
            CAPTURE: begin
                wr_en   = 1'b1;
                wr_addr = j_idx;
                wr_data = max_in;
            end
            default: ;
        endcase
    end

    nw_row_buf #(
        .N  (N),
        .SW (SW)
    ) u_row_buf (
        .clk     (clk),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr_a (j_idx),
        .rdata_a (rd_up),
        .raddr_b (j_idx - JW'(1)),
        .rdata_b (rd_left)
    );

    // Operands are only driven while a cell is in flight.
    // For j>1 the left neighbour is already in the buffer at j-1
    // (written by the previous CAPTURE); at j=1 it is the row border in lx_r.
    assign a_idx   = i_m1;
    assign b_idx   = j_m1;
    assign value   = active && (a_char == b_char);
    assign diag    = active ? diag_r : '0;
    assign up      = active ? rd_up  : '0;
    assign lx      = !active ? '0 : ((j_m1 == '0) ? lx_r : rd_left);
    assign tb_addr = tb_we ? (AW'(i_m1) * AW'(N) + AW'(j_m1)) : '0;
    assign tb_data = tb_we ? symbol_in : '0;

`ifdef NW_SCORE_OUT_EN
    assign score_we   = tb_we;
    assign score_data = tb_we ? max_in : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            i_m1        <= '0;
            j_m1        <= '0;
            k           <= '0;
            border      <= '0;
            diag_r      <= '0;
            lx_r        <= '0;
            final_score <= '0;
            tb_we       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= INIT;
                        final_score <= '0;
                        i_m1        <= '0;
                        j_m1        <= '0;
                        k           <= '0;
                        border      <= '0;
                        busy        <= 1'b1;
                    end
                end
                INIT: begin
                    k      <= k + JW'(1);
                    border <= border + GAP_S;
                    if (k == JW'(N)) begin
                        state  <= ISSUE;
                        j_m1   <= '0;
                        diag_r <= '0;
                        lx_r   <= GAP_S;
                        border <= GAP_S;    // score(1,0)
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                    tb_we <= 1'b1;
                end
                CAPTURE: begin
                    tb_we  <= 1'b0;
                    diag_r <= rd_up;        // old up becomes next diag
                    lx_r   <= max_in;
                    if (!last_col) begin
                        j_m1  <= j_m1 + IW'(1);
                        state <= ISSUE;
                    end else if (!last_row) begin
                        i_m1   <= i_m1 + IW'(1);
                        j_m1   <= '0;
                        diag_r <= border;           // score(i,0), old i
                        lx_r   <= border + GAP_S;   // score(i+1,0)
                        border <= border + GAP_S;
                        state  <= ISSUE;
                    end else begin
                        final_score <= max_in;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// tb_nw_fill_ctrl: scoreboard bench for nw_fill_ctrl with N=4.
// A behavioural max cell drives max_in/symbol_in. Before each fill the
// full score matrix is computed with plain integer arithmetic and one
// expected record per cell is queued; a negedge monitor pops a record on
// every tb_we and compares address, indices, operands and arrow.
module tb_nw_fill_ctrl;
    import nw_pkg::*;

    localparam int N   = 4;
    localparam int SW  = 9;
    localparam int GAP = -2;
    localparam int IW  = $clog2(N);
    localparam int AW  = $clog2(N * N);
    localparam int LAT = N + 2 + 2 * N * N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [IW-1:0]        a_idx, b_idx;
    logic [1:0]           a_char, b_char;
    logic                 value;
    logic signed [SW-1:0] diag, up, lx, max_in, final_score;
    logic [2:0]           symbol_in, tb_data;
    logic                 tb_we, busy, done;
    logic [AW-1:0]        tb_addr;
    nw_state_e            state_dbg;
`ifdef NW_SCORE_OUT_EN
    logic                 score_we;
    logic signed [SW-1:0] score_data;
`endif

    nw_fill_ctrl #(.N(N), .GAP(GAP), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_idx       (a_idx),
        .b_idx       (b_idx),
        .a_char      (a_char),
        .b_char      (b_char),
        .value       (value),
        .diag        (diag),
        .up          (up),
        .lx          (lx),
        .max_in      (max_in),
        .symbol_in   (symbol_in),
        .tb_we       (tb_we),
        .tb_addr     (tb_addr),
        .tb_data     (tb_data),
        .busy        (busy),
        .done        (done),
        .final_score (final_score),
        .state       (state_dbg)
`ifdef NW_SCORE_OUT_EN
        ,
        .score_we    (score_we),
        .score_data  (score_data)
`endif
    );

    // ---------------- sequence memories + max cell ----------------
    logic [1:0] seq_a [0:N-1];
    logic [1:0] seq_b [0:N-1];

    assign a_char = seq_a[a_idx];
    assign b_char = seq_b[b_idx];

    always_comb begin
        int md, mu, ml;
        md = int'(diag) + (value ? MATCH : MISMATCH);
        mu = int'(up) + GAP;
        ml = int'(lx) + GAP;
        if (md >= mu && md >= ml) begin
            max_in = SW'(md); symbol_in = ARROW_DIAG;
        end else if (mu >= ml) begin
            max_in = SW'(mu); symbol_in = ARROW_UP;
        end else begin
            max_in = SW'(ml); symbol_in = ARROW_LX;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0]        addr;
        logic [IW-1:0]        ai;
        logic [IW-1:0]        bi;
        logic                 val;
        logic [2:0]           arrow;
        logic signed [SW-1:0] score;
        logic signed [SW-1:0] d;
        logic signed [SW-1:0] u;
        logic signed [SW-1:0] l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   exp_final = 0;
    int   vectors = 0;
    int   errors = 0;
    int   writes = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: whole matrix from the recurrence, then one record per cell.
    task automatic build_expect();
        int   s [0:N][0:N];
        int   d, u, l, best;
        logic [2:0] ar;
        exp_t e;
        exp_q.delete();
        for (int x = 0; x <= N; x++) begin
            s[x][0] = x * GAP;
            s[0][x] = x * GAP;
        end
        for (int i = 1; i <= N; i++) begin
            for (int j = 1; j <= N; j++) begin
                d = s[i-1][j-1] + ((seq_a[i-1] == seq_b[j-1]) ? MATCH : MISMATCH);
                u = s[i-1][j] + GAP;
                l = s[i][j-1] + GAP;
                if (d >= u && d >= l) begin best = d; ar = ARROW_DIAG; end
                else if (u >= l)      begin best = u; ar = ARROW_UP;   end
                else                  begin best = l; ar = ARROW_LX;   end
                s[i][j] = best;
                e.addr  = AW'((i - 1) * N + (j - 1));
                e.ai    = IW'(i - 1);
                e.bi    = IW'(j - 1);
                e.val   = (seq_a[i-1] == seq_b[j-1]);
                e.arrow = ar;
                e.score = SW'(best);
                e.d     = SW'(s[i-1][j-1]);
                e.u     = SW'(s[i-1][j]);
                e.l     = SW'(s[i][j-1]);
                exp_q.push_back(e);
            end
        end
        exp_final = s[N][N];
    endtask

    // Monitor: one popped record per traceback write.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (tb_we) begin
                writes++;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d, no write expected", tb_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (tb_addr !== mon_e.addr || a_idx !== mon_e.ai || b_idx !== mon_e.bi ||
                        value !== mon_e.val || tb_data !== mon_e.arrow ||
                        diag !== mon_e.d || up !== mon_e.u || lx !== mon_e.l) begin
                        errors++;
                        $display("FAIL cell_write: got addr=%0d a=%0d b=%0d v=%0b arrow=%b d=%0d u=%0d l=%0d, expected addr=%0d a=%0d b=%0d v=%0b arrow=%b d=%0d u=%0d l=%0d",
                                 tb_addr, a_idx, b_idx, value, tb_data, diag, up, lx,
                                 mon_e.addr, mon_e.ai, mon_e.bi, mon_e.val, mon_e.arrow,
                                 mon_e.d, mon_e.u, mon_e.l);
                    end
`ifdef NW_SCORE_OUT_EN
                    vectors++;
                    if (score_we !== 1'b1 || score_data !== mon_e.score) begin
                        errors++;
                        $display("FAIL score_out: got we=%0b data=%0d at addr %0d, expected we=1 data=%0d",
                                 score_we, score_data, tb_addr, mon_e.score);
                    end
`endif
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [1:0] code(input byte c);
        case (c)
            "A":     return NT_A;
            "C":     return NT_C;
            "G":     return NT_G;
            default: return NT_T;
        endcase
    endfunction

    task automatic load(input string sa, input string sb);
        for (int x = 0; x < N; x++) begin
            seq_a[x] = code(sa[x]);
            seq_b[x] = code(sb[x]);
        end
    endtask

    task automatic load_random();
        for (int x = 0; x < N; x++) begin
            seq_a[x] = 2'($urandom_range(0, 3));
            seq_b[x] = 2'($urandom_range(0, 3));
        end
    endtask

    // One complete fill; optional stray start pulses in INIT and CAPTURE.
    task automatic run_fill(input string tag, input bit noise);
        int  t0;
        bit  seen;
        int  held;
        build_expect();
        writes   = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_final_cleared"}, int'(final_score), 0);
        check({tag, "_busy_in_init"}, int'(busy), 1);
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = noise && ((cyc - t0 == 3) || (cyc - t0 == N + 3));
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_done_latency"}, cyc - t0, LAT);
            check({tag, "_final_score"}, int'(final_score), exp_final);
            check({tag, "_busy_at_done"}, int'(busy), 0);
            held = int'(final_score);
            repeat (4) @(negedge clk);
            check({tag, "_idle_after"}, int'(state_dbg), int'(IDLE));
            check({tag, "_busy_after"}, int'(busy), 0);
            check({tag, "_final_held"}, int'(final_score), held);
            check({tag, "_done_pulses"}, done_cnt, 1);
            check({tag, "_write_count"}, writes, N * N);
            check({tag, "_queue_empty"}, exp_q.size(), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        load("AAAA", "AAAA");
        repeat (3) @(negedge clk);
        check("rst_state", int'(state_dbg), int'(IDLE));
        check("rst_outputs", int'({tb_we, busy, done, value}), 0);
        check("rst_final", int'(final_score), 0);
        check("rst_operands", int'({diag, up, lx}), 0);
        rst = 1'b0;

        // Identical sequences: diagonal arrows, score +4.
        load("ACGT", "ACGT");
        run_fill("s1", 1'b0);
        check("s1_const", int'(final_score), 4);

        // All mismatches: score -4.
        load("AAAA", "CCCC");
        run_fill("s2", 1'b0);
        check("s2_const", int'(final_score), -4);

        // Shifted sequence; under +1/-1/-2 score(4,4) works out to -1.
        load("ACGT", "TACG");
        run_fill("s3", 1'b0);

        // Reset during the second row's ISSUE.
        load("ACGT", "ACGT");
        build_expect();
        writes = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                if (writes >= N + 1 && !tb_we) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit) check("rst_mid_reach", 0, 1);
            check("rst_mid_in_issue", int'(state_dbg), int'(ISSUE));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", int'(state_dbg), int'(IDLE));
        check("rst_mid_we_busy_done", int'({tb_we, busy, done}), 0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_writes", int'(tb_we), 0);
        exp_q.delete();
        run_fill("s4", 1'b0);
        check("s4_const", int'(final_score), 4);

        // Stray start pulses during INIT and CAPTURE.
        load("GATC", "GTTC");
        run_fill("s5", 1'b1);

        // Randomised sequences.
        for (int r = 0; r < 6; r++) begin
            load_random();
            run_fill($sformatf("rnd%0d", r), r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
